// File: rtl/aes_shift_rows_serial_if.sv
// Column stream bundle for aes_shift_rows_serial: one 32-bit state column per
// beat with valid/ready on both the input and the output side.
// Ports: mode_inv/in_valid/in_col/in_ready (input stream), out_valid/out_col/
//        out_last/out_inv/out_ready (output stream). slave = unit, master = peer.
interface aes_shift_rows_serial_if;
  logic        mode_inv;
  logic        in_valid;
  logic [31:0] in_col;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_col;
  logic        out_last;
  logic        out_inv;
  logic        out_ready;

  modport slave (
    input  mode_inv, in_valid, in_col, out_ready,
    output in_ready, out_valid, out_col, out_last, out_inv
  );

  modport master (
    output mode_inv, in_valid, in_col, out_ready,
    input  in_ready, out_valid, out_col, out_last, out_inv
  );
endinterface

// File: rtl/aes_shift_rows_serial.sv
// Purpose: column-serial AES ShiftRows/InvShiftRows over a ping-pong pair of NB-column banks.
// Latency: last input column accepted in cycle t -> shifted column 0 valid in cycle t+1 (if other bank idle).
// Backpressure: out_ready low freezes outputs; in_ready drops when the write bank is full/draining.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries mode_inv, in_valid/in_col/in_ready,
//        out_valid/out_col/out_last/out_inv/out_ready. Column bytes: [31:24]=row0 .. [7:0]=row3.
module aes_shift_rows_serial #(
  parameter int NB     = 4,
  parameter bit INV_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  aes_shift_rows_serial_if.slave  bus
);

  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $fatal(1, "aes_shift_rows_serial: NB must be 4, 6 or 8");
    end
  endgenerate

  localparam int IW = $clog2(NB);
  // Rijndael row offsets: rows 2 and 3 shift one further for 256-bit blocks.
  localparam int C2 = (NB == 8) ? 3 : 2;
  localparam int C3 = (NB == 8) ? 4 : 3;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FILLING  = 2'd1,
    ST_FULL     = 2'd2,
    ST_DRAINING = 2'd3
  } bank_st_e;

  logic [31:0]   mem_q [2][NB];
  logic [31:0]   mem_d [2][NB];
  bank_st_e      st_q  [2];
  bank_st_e      st_d  [2];
  logic          inv_q [2];
  logic          inv_d [2];
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_col_q, out_col_d;
  logic          out_last_q, out_last_d;
  logic          out_inv_q, out_inv_d;

  logic wr_fire;
  logic rd_fire;

  assign wr_fire = bus.in_valid && bus.in_ready;
  assign rd_fire = out_valid_q && bus.out_ready;

  // in_ready depends only on registered state; rst gating keeps it low while reset is held.
  assign bus.in_ready  = in_ready_q && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_inv   = out_inv_q;

  always_comb begin
    int sh;
    int src;
    sh        = 0;
    src       = 0;
    mem_d     = mem_q;
    st_d      = st_q;
    inv_d     = inv_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;

    // Read side first so a bank emptied this cycle can be re-targeted below.
    if (rd_fire) begin
      if (rd_idx_q == IW'(NB - 1)) begin
        rd_idx_d        = '0;
        st_d[rd_bank_q] = ST_EMPTY;
        rd_bank_d       = ~rd_bank_q;
      end else begin
        rd_idx_d = rd_idx_q + IW'(1);
      end
    end

    if (wr_fire) begin
      mem_d[wr_bank_q][wr_idx_q] = bus.in_col;
      if (wr_idx_q == '0) begin
        st_d[wr_bank_q]  = ST_FILLING;
        inv_d[wr_bank_q] = INV_EN && bus.mode_inv;
      end
      if (wr_idx_q == IW'(NB - 1)) begin
        st_d[wr_bank_q] = ST_FULL;
        wr_idx_d        = '0;
        wr_bank_d       = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + IW'(1);
      end
    end

    // A full bank that is (or just became) the read bank starts draining at once,
    // which gives the single-cycle fill-to-output latency.
    if (st_d[rd_bank_d] == ST_FULL) begin
      st_d[rd_bank_d] = ST_DRAINING;
    end

    in_ready_d  = (st_d[wr_bank_d] == ST_EMPTY) || (st_d[wr_bank_d] == ST_FILLING);
    out_valid_d = (st_d[rd_bank_d] == ST_DRAINING);
    out_inv_d   = out_valid_d && inv_d[rd_bank_d];
    out_last_d  = out_valid_d && (rd_idx_d == IW'(NB - 1));

    // Outputs are precomputed from next state so they leave the unit registered.
    out_col_d = '0;
    if (out_valid_d) begin
      for (int r = 0; r < 4; r++) begin
        sh = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? C2 : C3;
        if (out_inv_d) begin
          src = int'(rd_idx_d) - sh + NB;
        end else begin
          src = int'(rd_idx_d) + sh;
        end
        if (src >= NB) begin
          src = src - NB;
        end
        out_col_d[31-8*r -: 8] = mem_d[rd_bank_d][src[IW-1:0]][31-8*r -: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      st_q        <= '{ST_EMPTY, ST_EMPTY};
      inv_q       <= '{1'b0, 1'b0};
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
      out_inv_q   <= 1'b0;
    end else begin
      st_q        <= st_d;
      inv_q       <= inv_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      out_last_q  <= out_last_d;
      out_inv_q   <= out_inv_d;
    end
  end

endmodule

// File: tb/tb_aes_shift_rows_serial.sv
// Bench for aes_shift_rows_serial: NB=4 and NB=8 instances, directed column vectors.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_aes_shift_rows_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_shift_rows_serial_if b4();
  aes_shift_rows_serial_if b8();

  aes_shift_rows_serial #(.NB(4), .INV_EN(1'b1)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
  aes_shift_rows_serial #(.NB(8), .INV_EN(1'b1)) u_dut8 (.clk(clk), .rst(rst), .bus(b8));

  int errors = 0;
  int checks = 0;

  logic [31:0] a_in  [4] = '{32'hd42711ae, 32'he0bf98f1, 32'hb8b45de5, 32'h1e415230};
  logic [31:0] a_out [4] = '{32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5};
  logic [31:0] b_out [4] = '{32'hd4b411e5, 32'he0419830, 32'hb8275dae, 32'h1ebf52f1};
  logic [31:0] c_in  [4] = '{32'h00102030, 32'h01112131, 32'h02122232, 32'h03132333};
  logic [31:0] c_out [4] = '{32'h00112233, 32'h01122330, 32'h02132031, 32'h03102132};
  logic [31:0] d_in  [8] = '{32'h00102030, 32'h01112131, 32'h02122232, 32'h03132333,
                             32'h04142434, 32'h05152535, 32'h06162636, 32'h07172737};
  logic [31:0] d_out [8] = '{32'h00112334, 32'h01122435, 32'h02132536, 32'h03142637,
                             32'h04152730, 32'h05162031, 32'h06172132, 32'h07102233};

  logic [31:0] in_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_col[$];
  bit          got_last[$];
  bit          got_inv[$];
  int          got_cyc[$];
  int          acc_cyc[$];
  logic [31:0] hold_col[$];
  bit          rdy_trace[$];
  int          stall_cnt;

  // Drives in_q into one instance and records every output transfer.
  task automatic run_stream(input bit use8, input int n_out, input bit inv_first,
                            input int hold, input int max_cyc);
    int k;
    int nb;
    int n_in;
    bit vld, minv, ordy, rdy, ov, ol, oi;
    logic [31:0] col, oc;
    k = 0;
    nb = use8 ? 8 : 4;
    n_in = in_q.size();
    got_col.delete(); got_last.delete(); got_inv.delete(); got_cyc.delete();
    acc_cyc.delete(); hold_col.delete(); rdy_trace.delete();
    stall_cnt = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (k < n_in) begin
        vld = 1'b1; col = in_q[k]; minv = inv_first && ((k % nb) == 0);
      end else begin
        vld = 1'b0; col = '0; minv = 1'b0;
      end
      ordy = (c >= hold);
      if (use8) begin
        b8.in_valid = vld; b8.in_col = col; b8.mode_inv = minv; b8.out_ready = ordy;
      end else begin
        b4.in_valid = vld; b4.in_col = col; b4.mode_inv = minv; b4.out_ready = ordy;
      end
      #1;
      rdy = use8 ? b8.in_ready  : b4.in_ready;
      ov  = use8 ? b8.out_valid : b4.out_valid;
      oc  = use8 ? b8.out_col   : b4.out_col;
      ol  = use8 ? b8.out_last  : b4.out_last;
      oi  = use8 ? b8.out_inv   : b4.out_inv;
      rdy_trace.push_back(rdy);
      if (k < n_in && !rdy) stall_cnt++;
      if (vld && rdy) begin
        acc_cyc.push_back(c);
        k++;
      end
      if (ov && !ordy) hold_col.push_back(oc);
      if (ov && ordy) begin
        got_col.push_back(oc); got_last.push_back(ol); got_inv.push_back(oi); got_cyc.push_back(c);
      end
      if (k >= n_in && got_col.size() >= n_out) break;
    end
    @(negedge clk);
    b4.in_valid = 1'b0; b4.mode_inv = 1'b0; b4.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.mode_inv = 1'b0; b8.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (b4.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", b4.in_ready); end
    checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", b4.out_valid); end
    checks++; if (b4.out_col !== 32'h0) begin errors++; $display("FAIL reset_out_col: got %h want 0", b4.out_col); end
    checks++; if ({b4.out_last, b4.out_inv} !== 2'b00) begin errors++; $display("FAIL reset_last_inv: got %b want 00", {b4.out_last, b4.out_inv}); end
    checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid8: got %b want 0", b8.out_valid); end
    rst = 1'b0;
    #1;
    checks++; if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", b4.in_ready); end
    checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready8: got %b want 1", b8.in_ready); end
  endtask

  task automatic test_forward4();
    in_q.delete();
    for (int i = 0; i < 4; i++) in_q.push_back(a_in[i]);
    run_stream(1'b0, 4, 1'b0, 0, 100);
    checks++; if (got_col.size() != 4) begin errors++; $display("FAIL fwd4_count: got %0d want 4", got_col.size()); end
    for (int i = 0; i < got_col.size() && i < 4; i++) begin
      checks++; if (got_col[i] !== a_out[i]) begin errors++; $display("FAIL fwd4_col%0d: got %h want %h", i, got_col[i], a_out[i]); end
      checks++; if (got_last[i] !== (i == 3)) begin errors++; $display("FAIL fwd4_last%0d: got %b want %b", i, got_last[i], i == 3); end
      checks++; if (got_inv[i] !== 1'b0) begin errors++; $display("FAIL fwd4_inv%0d: got %b want 0", i, got_inv[i]); end
    end
    if (got_col.size() > 0 && acc_cyc.size() == 4) begin
      checks++; if (got_cyc[0] != acc_cyc[3] + 1) begin errors++; $display("FAIL fwd4_latency: got cycle %0d want %0d", got_cyc[0], acc_cyc[3] + 1); end
    end
  endtask

  task automatic test_inverse4();
    in_q.delete();
    for (int i = 0; i < 4; i++) in_q.push_back(a_out[i]);
    run_stream(1'b0, 4, 1'b1, 0, 100);
    checks++; if (got_col.size() != 4) begin errors++; $display("FAIL inv4_count: got %0d want 4", got_col.size()); end
    for (int i = 0; i < got_col.size() && i < 4; i++) begin
      checks++; if (got_col[i] !== a_in[i]) begin errors++; $display("FAIL inv4_col%0d: got %h want %h", i, got_col[i], a_in[i]); end
      checks++; if (got_inv[i] !== 1'b1) begin errors++; $display("FAIL inv4_inv%0d: got %b want 1", i, got_inv[i]); end
    end
  endtask

  task automatic test_back_to_back();
    in_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) begin in_q.push_back(a_in[i]);  exp_q.push_back(a_out[i]); end
    for (int i = 0; i < 4; i++) begin in_q.push_back(a_out[i]); exp_q.push_back(b_out[i]); end
    for (int i = 0; i < 4; i++) begin in_q.push_back(c_in[i]);  exp_q.push_back(c_out[i]); end
    run_stream(1'b0, 12, 1'b0, 0, 200);
    checks++; if (stall_cnt != 0) begin errors++; $display("FAIL b2b_in_ready_drops: got %0d stalls want 0", stall_cnt); end
    checks++; if (got_col.size() != 12) begin errors++; $display("FAIL b2b_count: got %0d want 12", got_col.size()); end
    for (int i = 0; i < got_col.size() && i < 12; i++) begin
      checks++; if (got_col[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_col%0d: got %h want %h", i, got_col[i], exp_q[i]); end
      checks++; if (got_cyc[i] != got_cyc[0] + i) begin errors++; $display("FAIL b2b_gap%0d: got cycle %0d want %0d", i, got_cyc[i], got_cyc[0] + i); end
    end
  endtask

  task automatic test_backpressure();
    in_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) begin in_q.push_back(a_in[i]);  exp_q.push_back(a_out[i]); end
    for (int i = 0; i < 4; i++) begin in_q.push_back(a_out[i]); exp_q.push_back(b_out[i]); end
    run_stream(1'b0, 8, 1'b0, 12, 200);
    checks++; if (acc_cyc.size() != 8 || acc_cyc[7] != 7) begin errors++; $display("FAIL bp_accept: got %0d accepts want 8 by cycle 7", acc_cyc.size()); end
    checks++; if (rdy_trace.size() < 12 || rdy_trace[8] !== 1'b0 || rdy_trace[11] !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b want 0", rdy_trace.size() > 8 ? rdy_trace[8] : 1'b1); end
    checks++; if (hold_col.size() != 8) begin errors++; $display("FAIL bp_hold_count: got %0d want 8", hold_col.size()); end
    for (int i = 0; i < hold_col.size(); i++) begin
      checks++; if (hold_col[i] !== a_out[0]) begin errors++; $display("FAIL bp_frozen%0d: got %h want %h", i, hold_col[i], a_out[0]); end
    end
    checks++; if (got_col.size() != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", got_col.size()); end
    for (int i = 0; i < got_col.size() && i < 8; i++) begin
      checks++; if (got_col[i] !== exp_q[i]) begin errors++; $display("FAIL bp_col%0d: got %h want %h", i, got_col[i], exp_q[i]); end
    end
    #1;
    checks++; if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_back: got %b want 1", b4.in_ready); end
  endtask

  task automatic test_nb8();
    in_q.delete();
    for (int i = 0; i < 8; i++) in_q.push_back(d_in[i]);
    run_stream(1'b1, 8, 1'b0, 0, 100);
    checks++; if (got_col.size() != 8) begin errors++; $display("FAIL nb8_fwd_count: got %0d want 8", got_col.size()); end
    for (int i = 0; i < got_col.size() && i < 8; i++) begin
      checks++; if (got_col[i] !== d_out[i]) begin errors++; $display("FAIL nb8_fwd_col%0d: got %h want %h", i, got_col[i], d_out[i]); end
      checks++; if (got_last[i] !== (i == 7)) begin errors++; $display("FAIL nb8_last%0d: got %b want %b", i, got_last[i], i == 7); end
    end
    in_q.delete();
    for (int i = 0; i < 8; i++) in_q.push_back(d_out[i]);
    run_stream(1'b1, 8, 1'b1, 0, 100);
    checks++; if (got_col.size() != 8) begin errors++; $display("FAIL nb8_inv_count: got %0d want 8", got_col.size()); end
    for (int i = 0; i < got_col.size() && i < 8; i++) begin
      checks++; if (got_col[i] !== d_in[i]) begin errors++; $display("FAIL nb8_inv_col%0d: got %h want %h", i, got_col[i], d_in[i]); end
      checks++; if (got_inv[i] !== 1'b1) begin errors++; $display("FAIL nb8_inv_flag%0d: got %b want 1", i, got_inv[i]); end
    end
  endtask

  task automatic test_reset_mid_block();
    int accepted;
    int stray;
    accepted = 0;
    stray = 0;
    for (int c = 0; c < 20 && accepted < 2; c++) begin
      @(negedge clk);
      b4.in_valid = 1'b1; b4.in_col = a_in[accepted]; b4.mode_inv = 1'b0; b4.out_ready = 1'b1;
      #1;
      if (b4.in_ready) accepted++;
    end
    @(negedge clk);
    b4.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b4.out_valid) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rstmid_stray_pre: got %0d valid cycles want 0", stray); end
    in_q.delete();
    for (int i = 0; i < 4; i++) in_q.push_back(c_in[i]);
    run_stream(1'b0, 4, 1'b0, 0, 100);
    checks++; if (got_col.size() != 4) begin errors++; $display("FAIL rstmid_count: got %0d want 4", got_col.size()); end
    for (int i = 0; i < got_col.size() && i < 4; i++) begin
      checks++; if (got_col[i] !== c_out[i]) begin errors++; $display("FAIL rstmid_col%0d: got %h want %h", i, got_col[i], c_out[i]); end
    end
    if (got_col.size() > 0 && acc_cyc.size() == 4) begin
      checks++; if (got_cyc[0] != acc_cyc[3] + 1) begin errors++; $display("FAIL rstmid_latency: got cycle %0d want %0d", got_cyc[0], acc_cyc[3] + 1); end
    end
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b4.out_valid) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rstmid_stray_post: got %0d valid cycles want 0", stray); end
  endtask

  initial begin
    b4.in_valid = 1'b0; b4.in_col = '0; b4.mode_inv = 1'b0; b4.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.in_col = '0; b8.mode_inv = 1'b0; b8.out_ready = 1'b1;
    test_reset();
    test_forward4();
    test_inverse4();
    test_back_to_back();
    test_backpressure();
    test_nb8();
    test_reset_mid_block();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
